// File: rtl/vram_pkg.sv
// Shared constants and writer state type for the 1-bpp video frame RAMs.
package vram_pkg;

   localparam int H_PIXELS     = 128;
   localparam int V_PIXELS     = 96;
   localparam int ADDR_W       = 14;
   localparam int X_W          = 7;
   localparam int Y_W          = 7;
   localparam int FRAME_PIXELS = H_PIXELS * V_PIXELS;

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } wr_state_t;

endpackage

// File: rtl/vram_addr_gen.sv
// Combinational (x, y) -> linear frame address with an in-range flag.
// The address wraps modulo 2^ADDR_W; the flag reports x < H_PIXELS and y < V_PIXELS.
module vram_addr_gen
   import vram_pkg::*;
#(
   parameter int H_PIXELS = vram_pkg::H_PIXELS,
   parameter int V_PIXELS = vram_pkg::V_PIXELS,
   parameter int ADDR_W   = vram_pkg::ADDR_W,
   parameter int X_W      = vram_pkg::X_W,
   parameter int Y_W      = vram_pkg::Y_W
) (
   input  logic [X_W-1:0]    x_i,
   input  logic [Y_W-1:0]    y_i,
   output logic [ADDR_W-1:0] addr_o,
   output logic              in_range_o
);

   always_comb begin
      addr_o     = ADDR_W'(y_i) * ADDR_W'(H_PIXELS) + ADDR_W'(x_i);
      in_range_o = (int'(x_i) < H_PIXELS) && (int'(y_i) < V_PIXELS);
   end

endmodule

// File: rtl/vram_pixel_writer.sv
// Write-side master for one 1-bpp frame RAM: single-pixel writes plus a full-frame fill sweep.
// Define VRAM_WRITER_BOUNDS_CHECK_EN to drop out-of-range pixels and flag them on err_oob.
module vram_pixel_writer
   import vram_pkg::*;
#(
   parameter int H_PIXELS = vram_pkg::H_PIXELS,
   parameter int V_PIXELS = vram_pkg::V_PIXELS,
   parameter int ADDR_W   = vram_pkg::ADDR_W,
   parameter int X_W      = vram_pkg::X_W,
   parameter int Y_W      = vram_pkg::Y_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              px_valid,
   output logic              px_ready,
   input  logic [X_W-1:0]    px_x,
   input  logic [Y_W-1:0]    px_y,
   input  logic              px_val,
   input  logic              fill_start,
   input  logic              fill_val,
   output logic              busy,
   output logic              done,
   output logic              err_oob,
   output logic              ram_en,
   output logic [1:0]        ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_din
);

`ifdef VRAM_WRITER_BOUNDS_CHECK_EN
   localparam bit BOUNDS_EN = 1'b1;
`else
   localparam bit BOUNDS_EN = 1'b0;
`endif

   localparam int FRAME_PIX = H_PIXELS * V_PIXELS;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);

   wr_state_t         state_q, state_d;
   logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
   logic              fill_val_q, fill_val_d;
   logic              ram_en_q, ram_en_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic              ram_din_q, ram_din_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_oob_q, err_oob_d;

   logic [ADDR_W-1:0] pix_addr;
   logic              pix_in_range;
   logic              px_fire;
   logic              pix_wr_ok;

   vram_addr_gen #(
      .H_PIXELS (H_PIXELS),
      .V_PIXELS (V_PIXELS),
      .ADDR_W   (ADDR_W),
      .X_W      (X_W),
      .Y_W      (Y_W)
   ) u_addr_gen (
      .x_i        (px_x),
      .y_i        (px_y),
      .addr_o     (pix_addr),
      .in_range_o (pix_in_range)
   );

   assign px_ready  = (state_q == IDLE) && !reset;
   assign px_fire   = px_valid && px_ready;
   assign pix_wr_ok = !BOUNDS_EN || pix_in_range;

   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      fill_val_d = fill_val_q;
      ram_en_d   = 1'b0;
      ram_addr_d = '0;
      ram_din_d  = 1'b0;
      done_d     = 1'b0;
      err_oob_d  = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Pixel and fill_start in the same cycle: the pixel goes out now, the sweep follows.
            if (px_fire) begin
               if (pix_wr_ok) begin
                  ram_en_d   = 1'b1;
                  ram_addr_d = pix_addr;
                  ram_din_d  = px_val;
               end else begin
                  err_oob_d  = 1'b1;
               end
            end
            if (fill_start) begin
               fill_val_d = fill_val;
               fill_cnt_d = '0;
               state_d    = FILL;
            end
         end
         FILL: begin
            ram_en_d   = 1'b1;
            ram_addr_d = fill_cnt_q;
            ram_din_d  = fill_val_q;
            if (fill_cnt_q == LAST_ADDR) begin
               done_d     = 1'b1;
               fill_cnt_d = '0;
               state_d    = IDLE;
            end else begin
               fill_cnt_d = fill_cnt_q + ADDR_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d == FILL);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         fill_cnt_q <= '0;
         fill_val_q <= 1'b0;
         ram_en_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_oob_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
         fill_val_q <= fill_val_d;
         ram_en_q   <= ram_en_d;
         ram_addr_q <= ram_addr_d;
         ram_din_q  <= ram_din_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_oob_q  <= err_oob_d;
      end
   end

   assign ram_en   = ram_en_q;
   assign ram_we   = {2{ram_en_q}};
   assign ram_addr = ram_addr_q;
   assign ram_din  = ram_din_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err_oob  = err_oob_q;

endmodule

// File: tb/tb_vram_pixel_writer.sv
// Self-checking bench for vram_pixel_writer: vector table, random pixels vs arithmetic model,
// and hand sequences for fills, pixel+fill collision, and reset mid-fill.
module tb_vram_pixel_writer;

   localparam int H  = 128;
   localparam int V  = 96;
   localparam int F  = H * V;
   localparam int AW = 14;

`ifdef VRAM_WRITER_BOUNDS_CHECK_EN
   localparam bit B = 1'b1;
`else
   localparam bit B = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          px_valid;
   logic          px_ready;
   logic [6:0]    px_x;
   logic [6:0]    px_y;
   logic          px_val;
   logic          fill_start;
   logic          fill_val;
   logic          busy;
   logic          done;
   logic          err_oob;
   logic          ram_en;
   logic [1:0]    ram_we;
   logic [AW-1:0] ram_addr;
   logic          ram_din;

   int n_tests = 0;
   int n_fail  = 0;

   vram_pixel_writer dut (
      .clk        (clk),
      .reset      (reset),
      .px_valid   (px_valid),
      .px_ready   (px_ready),
      .px_x       (px_x),
      .px_y       (px_y),
      .px_val     (px_val),
      .fill_start (fill_start),
      .fill_val   (fill_val),
      .busy       (busy),
      .done       (done),
      .err_oob    (err_oob),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_addr   (ram_addr),
      .ram_din    (ram_din)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int model_addr(input int x, input int y);
      return (y * H + x) % (1 << AW);
   endfunction

   function automatic logic [20:0] obs();
      return {ram_en, ram_we, ram_din, done, busy, px_ready, ram_addr};
   endfunction

   // Fill from IDLE; optionally a pixel in the same cycle, and a stray fill_start mid-sweep.
   task automatic do_fill(input bit v, input bit with_pixel);
      logic [20:0] exp;
      chk("fill_ready_pre", px_ready, 1);
      fill_start = 1'b1;
      fill_val   = v;
      if (with_pixel) begin
         px_valid = 1'b1; px_x = 7'd5; px_y = 7'd2; px_val = 1'b1;
      end
      tick;
      fill_start = 1'b0;
      px_valid   = 1'b0;
      if (with_pixel)
         chk("pix_before_fill", {ram_en, ram_we, ram_din, ram_addr}, {1'b1, 2'b11, 1'b1, 14'd261});
      else
         chk("fill_first_cycle_en", ram_en, 0);
      chk("fill_first_cycle_busy_ready", {busy, px_ready, done}, 3'b100);
      for (int k = 0; k < F; k++) begin
         if (k == 100) begin
            fill_start = 1'b1;
            fill_val   = ~v;
         end else begin
            fill_start = 1'b0;
            fill_val   = v;
         end
         tick;
         exp = {1'b1, 2'b11, v, (k == F - 1), (k < F - 1), (k == F - 1), 14'(k)};
         chk("fill", obs(), exp);
      end
      fill_start = 1'b0;
      tick;
      chk("fill_after", {ram_en, busy, done, px_ready}, 4'b0001);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("no_refill", {ram_en, busy, done}, 3'b000);
      end
   endtask

   typedef struct {
      int x;
      int y;
      bit val;
      int exp_addr;
      bit exp_en;
      bit exp_err;
   } pvec_t;

   pvec_t tbl[7];

   initial begin
      int x, y;
      bit v, en, oob;

      tbl[0] = '{5,   2,   1'b1, 261,   1'b1, 1'b0};
      tbl[1] = '{0,   0,   1'b0, 0,     1'b1, 1'b0};
      tbl[2] = '{127, 95,  1'b1, 12287, 1'b1, 1'b0};
      tbl[3] = '{0,   95,  1'b1, 12160, 1'b1, 1'b0};
      tbl[4] = '{127, 0,   1'b0, 127,   1'b1, 1'b0};
      tbl[5] = '{127, 96,  1'b1, 12415, !B,   B};
      tbl[6] = '{3,   127, 1'b1, 16259, !B,   B};

      reset = 1'b1; px_valid = 1'b0; px_x = '0; px_y = '0; px_val = 1'b0;
      fill_start = 1'b0; fill_val = 1'b0;
      tick;
      tick;
      chk("rst_ready", px_ready, 0);
      chk("rst_outs", {ram_en, ram_we, ram_din, busy, done, err_oob, ram_addr}, 0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", px_ready, 1);

      // Solo pixel: write at N+1 only
      px_valid = 1'b1; px_x = 7'd5; px_y = 7'd2; px_val = 1'b1;
      tick;
      px_valid = 1'b0;
      chk("solo_write", {ram_en, ram_we, ram_din, ram_addr}, {1'b1, 2'b11, 1'b1, 14'd261});
      tick;
      chk("solo_one_cycle", ram_en, 0);

      // Back-to-back table vectors
      for (int i = 0; i < 7; i++) begin
         px_valid = 1'b1;
         px_x = 7'(tbl[i].x); px_y = 7'(tbl[i].y); px_val = tbl[i].val;
         chk("tbl_ready", px_ready, 1);
         tick;
         chk("tbl_en", ram_en, tbl[i].exp_en);
         chk("tbl_we", ram_we, {2{tbl[i].exp_en}});
         chk("tbl_err", err_oob, tbl[i].exp_err);
         if (tbl[i].exp_en) begin
            chk("tbl_addr", ram_addr, tbl[i].exp_addr);
            chk("tbl_din", ram_din, tbl[i].val);
         end
      end
      px_valid = 1'b0;
      tick;
      chk("tbl_idle", {ram_en, err_oob}, 2'b00);

      // Random pixels vs arithmetic model
      for (int i = 0; i < 300; i++) begin
         en  = ($urandom_range(0, 3) != 0);
         x   = $urandom_range(0, 127);
         y   = $urandom_range(0, 127);
         v   = 1'($urandom_range(0, 1));
         oob = (x >= H) || (y >= V);
         px_valid = en; px_x = 7'(x); px_y = 7'(y); px_val = v;
         chk("rnd_ready", px_ready, 1);
         tick;
         chk("rnd_en", ram_en, en && (!B || !oob));
         chk("rnd_err", err_oob, en && B && oob);
         if (en && (!B || !oob)) begin
            chk("rnd_addr", ram_addr, model_addr(x, y));
            chk("rnd_din", ram_din, v);
         end
      end
      px_valid = 1'b0;
      tick;

      do_fill(1'b0, 1'b0);
      do_fill(1'b1, 1'b1);

      // Reset at fill address 3000
      fill_start = 1'b1; fill_val = 1'b1;
      tick;
      fill_start = 1'b0;
      for (int k = 0; k <= 3000; k++) tick;
      chk("rst_mid_addr", {ram_en, ram_addr}, {1'b1, 14'd3000});
      reset = 1'b1;
      tick;
      chk("rst_mid_en", {ram_en, done, busy, px_ready}, 4'b0000);
      reset = 1'b0;
      #1;
      chk("rst_mid_ready", px_ready, 1);
      for (int i = 0; i < 3; i++) begin
         tick;
         chk("rst_mid_quiet", {ram_en, done, busy, px_ready}, 4'b0001);
      end
      // Counter restarts from 0 after the abort
      fill_start = 1'b1; fill_val = 1'b0;
      tick;
      fill_start = 1'b0;
      tick;
      chk("refill_addr0", {ram_en, ram_din, ram_addr}, {1'b1, 1'b0, 14'd0});
      tick;
      chk("refill_addr1", ram_addr, 1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      #1;
      chk("final_ready", {px_ready, ram_en, busy}, 3'b100);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
